mem_copy_engine: RTL and testbench

//   Request-side initiator for the split read/write memory request interface.

---
 rtl/mem_copy_engine_if.sv | 50 +++++
 rtl/mem_copy_engine.sv | 178 +++++++++++++++++
 tb/tb_mem_copy_engine.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_copy_engine_if.sv
// Split read/write memory request bus between the copy engine (master)
// and the memory responder (slave). Request channels carry address, beat
// count and size code; data channels carry one word per beat.
interface mem_copy_engine_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // read request channel
  logic          read_request_valid;
  logic          read_request_ready;
  logic [AW-1:0] read_request_addr;
  logic [31:0]   read_len;
  logic [2:0]    read_size;
  // read data channel
  logic [DW-1:0] read_data;
  logic          read_data_valid;
  logic          read_data_ready;
  // write request channel
  logic          write_request_valid;
  logic          write_request_ready;
  logic [AW-1:0] write_request_addr;
  logic [31:0]   write_len;
  logic [2:0]    write_size;
  // write data channel
  logic [DW-1:0] write_data;
  logic          write_data_valid;
  logic          write_data_ready;

  modport master (
    output read_request_valid, read_request_addr, read_len, read_size,
    input  read_request_ready,
    input  read_data, read_data_valid,
    output read_data_ready,
    output write_request_valid, write_request_addr, write_len, write_size,
    input  write_request_ready,
    output write_data, write_data_valid,
    input  write_data_ready
  );

  modport slave (
    input  read_request_valid, read_request_addr, read_len, read_size,
    output read_request_ready,
    output read_data, read_data_valid,
    input  read_data_ready,
    input  write_request_valid, write_request_addr, write_len, write_size,
    output write_request_ready,
    input  write_data, write_data_valid,
    output write_data_ready
  );
endinterface

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: copies len words from src_addr to dst_addr using one read
// request and one write request, streaming read beats through a small FIFO
// into write beats. One transfer at a time.
// Optional feature: define MEM_COPY_CHECKSUM_EN to add a running sum of all
// written words on the checksum port.
module mem_copy_engine #(
  parameter int AXI_AWIDTH = 32,
  parameter int AXI_DWIDTH = 32,
  parameter int FIFO_LOGD  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [AXI_AWIDTH-1:0] src_addr,
  input  logic [AXI_AWIDTH-1:0] dst_addr,
  input  logic [31:0]           len,
  output logic                  busy,
  output logic                  done,
`ifdef MEM_COPY_CHECKSUM_EN
  output logic [AXI_DWIDTH-1:0] checksum,
`endif
  mem_copy_engine_if.master     bus
);

  localparam int DEPTH = 1 << FIFO_LOGD;
  localparam logic [FIFO_LOGD:0]    OCC_FULL  = (FIFO_LOGD+1)'(DEPTH);
  // byte addresses are word aligned by clearing the two low bits
  localparam logic [AXI_AWIDTH-1:0] WORD_MASK = {{(AXI_AWIDTH-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

  state_t                  state;
  logic                    busy_q, done_q;
  logic                    rreq_v, wreq_v;
  logic                    rd_req_done, wr_req_done;
  logic [AXI_AWIDTH-1:0]   src_q, dst_q;
  logic [31:0]             len_q;
  logic [31:0]             rd_cnt, wr_cnt;

  logic [AXI_DWIDTH-1:0]   fifo_mem [DEPTH];
  logic [FIFO_LOGD-1:0]    wptr, rptr;
  logic [FIFO_LOGD:0]      occ;

  logic in_xfer, fifo_full, fifo_empty;
  logic rd_ready, push, pop;
  logic rreq_fire, wreq_fire, launch;

  assign in_xfer    = (state == XFER);
  assign fifo_full  = (occ == OCC_FULL);
  assign fifo_empty = (occ == '0);
  // stop accepting read beats once the whole transfer has been read
  assign rd_ready   = in_xfer && !fifo_full && (rd_cnt != len_q);
  assign push       = rd_ready && bus.read_data_valid;
  assign pop        = in_xfer && !fifo_empty && bus.write_data_ready;
  assign rreq_fire  = rreq_v && bus.read_request_ready;
  assign wreq_fire  = wreq_v && bus.write_request_ready;
  assign launch     = (state == IDLE) && start;

  assign busy                    = busy_q;
  assign done                    = done_q;
  assign bus.read_request_valid  = rreq_v;
  assign bus.read_request_addr   = src_q & WORD_MASK;
  assign bus.read_len            = len_q;
  assign bus.read_size           = 3'd2;
  assign bus.read_data_ready     = rd_ready;
  assign bus.write_request_valid = wreq_v;
  assign bus.write_request_addr  = dst_q & WORD_MASK;
  assign bus.write_len           = len_q;
  assign bus.write_size          = 3'd2;
  assign bus.write_data          = fifo_mem[rptr];
  assign bus.write_data_valid    = in_xfer && !fifo_empty;

  // transfer control FSM with registered status and request valids
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rreq_v      <= 1'b0;
      wreq_v      <= 1'b0;
      rd_req_done <= 1'b0;
      wr_req_done <= 1'b0;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      rd_cnt      <= '0;
      wr_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (len != '0) begin
              src_q       <= src_addr;
              dst_q       <= dst_addr;
              len_q       <= len;
              rd_cnt      <= '0;
              wr_cnt      <= '0;
              rd_req_done <= 1'b0;
              wr_req_done <= 1'b0;
              rreq_v      <= 1'b1;
              wreq_v      <= 1'b1;
              state       <= REQ;
            end else begin
              // nothing to move: skip both requests
              done_q <= 1'b1;
              state  <= DONE;
            end
          end
        end
        REQ: begin
          if (rreq_fire) begin
            rreq_v      <= 1'b0;
            rd_req_done <= 1'b1;
          end
          if (wreq_fire) begin
            wreq_v      <= 1'b0;
            wr_req_done <= 1'b1;
          end
          if ((rd_req_done || rreq_fire) && (wr_req_done || wreq_fire))
            state <= XFER;
        end
        XFER: begin
          if (push) rd_cnt <= rd_cnt + 32'd1;
          if (pop) begin
            wr_cnt <= wr_cnt + 32'd1;
            if (wr_cnt + 32'd1 == len_q) begin
              done_q <= 1'b1;
              state  <= DONE;
            end
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO pointers and occupancy; a pop and push in one cycle cancel out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else if (launch) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // FIFO storage; contents are only meaningful below the occupancy count
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr] <= bus.read_data;
  end

`ifdef MEM_COPY_CHECKSUM_EN
  // running sum of written words, kept after done until the next launch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      checksum <= '0;
    else if (launch) checksum <= '0;
    else if (pop)    checksum <= checksum + bus.write_data;
  end
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: a responder process serves the memory bus,
// read beats go into a scoreboard queue and are compared against write beats.
module tb_mem_copy_engine;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0, dst_addr = '0, len = '0;
  logic        busy, done;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  mem_copy_engine_if #(.AW(32), .DW(32)) mif();

  mem_copy_engine #(.AXI_AWIDTH(32), .AXI_DWIDTH(32), .FIFO_LOGD(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
    .busy     (busy),
    .done     (done),
`ifdef MEM_COPY_CHECKSUM_EN
    .checksum (checksum),
`endif
    .bus      (mif.master)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // responder / monitor state
  logic [31:0] src_mem [64];
  logic [31:0] sb [$];
  logic [31:0] exp_raddr, exp_waddr, exp_len, exp_sum, prev_waddr;
  int  cyc = 0, rd_beat = 0, cur_len = 0, hold_cnt = 0, wr_delay = 0, wv_cyc = 0;
  int  push_cnt = 0, pop_cnt = 0, done_cnt = 0, rv_seen = 0, wv_seen = 0;
  int  rreq_fires = 0, wreq_fires = 0, last_wf_cyc = 0;
  bit  rreq_ok = 0, chk_lat = 0;
  bit  r_f, w_f, d_f, q_f;
  bit  prev_rv, prev_wv, prev_rf, prev_wf, prev_done;

  // responder: observe at negedge, drive just after posedge
  initial begin
    mif.read_request_ready  = 1'b0;
    mif.write_request_ready = 1'b0;
    mif.read_data_valid     = 1'b0;
    mif.read_data           = '0;
    mif.write_data_ready    = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      r_f = 0; w_f = 0; d_f = 0; q_f = 0;
      if (!rst_n) begin
        prev_rv = 0; prev_wv = 0; prev_rf = 0; prev_wf = 0; prev_done = 0;
      end else begin
        r_f = mif.read_request_valid  && mif.read_request_ready;
        w_f = mif.write_request_valid && mif.write_request_ready;
        d_f = mif.read_data_valid     && mif.read_data_ready;
        q_f = mif.write_data_valid    && mif.write_data_ready;
        if (prev_rf)      chk("rreq_drop", 32'(mif.read_request_valid), 0);
        else if (prev_rv) chk("rreq_hold", 32'(mif.read_request_valid), 1);
        if (prev_wf)      chk("wreq_drop", 32'(mif.write_request_valid), 0);
        else if (prev_wv) begin
          chk("wreq_hold", 32'(mif.write_request_valid), 1);
          chk("waddr_stable", mif.write_request_addr, prev_waddr);
        end
        if (mif.read_request_valid)  rv_seen++;
        if (mif.write_request_valid) begin wv_seen++; wv_cyc++; end
        if (r_f) begin
          rreq_fires++;
          chk("raddr", mif.read_request_addr, exp_raddr);
          chk("rlen", mif.read_len, exp_len);
          chk("rsize", 32'(mif.read_size), 2);
        end
        if (w_f) begin
          wreq_fires++;
          chk("waddr", mif.write_request_addr, exp_waddr);
          chk("wlen", mif.write_len, exp_len);
          chk("wsize", 32'(mif.write_size), 2);
        end
        if (q_f) begin
          chk("sb_level", 32'(sb.size() != 0), 1);
          if (sb.size() != 0) chk("wdata", mif.write_data, sb.pop_front());
          exp_sum = exp_sum + mif.write_data;
          pop_cnt++;
          last_wf_cyc = cyc;
        end
        if (d_f) begin
          sb.push_back(mif.read_data);
          push_cnt++;
        end
        if (done) begin
          done_cnt++;
          chk("done_width", 32'(prev_done), 0);
          if (chk_lat) chk("done_lat", cyc, last_wf_cyc + 1);
        end
        prev_rv = mif.read_request_valid;  prev_rf = r_f;
        prev_wv = mif.write_request_valid; prev_wf = w_f;
        prev_waddr = mif.write_request_addr;
        prev_done = done;
      end
      @(posedge clk); #1;
      if (!rst_n) rreq_ok = 0;
      else begin
        if (r_f) rreq_ok = 1;
        if (d_f) rd_beat++;
      end
      mif.read_request_ready  = 1'b1;
      mif.write_request_ready = (wv_cyc >= wr_delay);
      mif.read_data_valid     = rst_n && rreq_ok && (rd_beat < cur_len);
      mif.read_data           = src_mem[rd_beat % 64];
      mif.write_data_ready    = (hold_cnt == 0);
      if (hold_cnt > 0) hold_cnt--;
    end
  end

  task automatic setup(input logic [31:0] s, d, n, input int hold, dly, input bit rnd);
    cur_len = int'(n); rd_beat = 0; rreq_ok = 0; wv_cyc = 0;
    hold_cnt = hold; wr_delay = dly;
    exp_raddr = s & ~32'd3; exp_waddr = d & ~32'd3; exp_len = n;
    push_cnt = 0; pop_cnt = 0; rv_seen = 0; wv_seen = 0; exp_sum = 0;
    rreq_fires = 0; wreq_fires = 0; sb.delete();
    chk_lat = (n != 0);
    if (rnd) for (int i = 0; i < 64; i++) src_mem[i] = $urandom;
  endtask

  task automatic launch(input logic [31:0] s, d, n, input int hold, dly, input bit rnd);
    @(posedge clk); #3;
    setup(s, d, n, hold, dly, rnd);
    src_addr = s; dst_addr = d; len = n; start = 1'b1;
    @(posedge clk); #3;
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input int max);
    for (int i = 0; i < max; i++) begin
      @(posedge clk); #3;
      if (done_cnt > base) break;
    end
    chk("done_seen", 32'(done_cnt > base), 1);
    chk("busy_idle", 32'(busy), 0);
  endtask

  task automatic chk_reset_outs(input string pfx);
    chk({pfx, "_busy"},   32'(busy), 0);
    chk({pfx, "_done"},   32'(done), 0);
    chk({pfx, "_rv"},     32'(mif.read_request_valid), 0);
    chk({pfx, "_wv"},     32'(mif.write_request_valid), 0);
    chk({pfx, "_rdrdy"},  32'(mif.read_data_ready), 0);
    chk({pfx, "_wdv"},    32'(mif.write_data_valid), 0);
    chk({pfx, "_raddr"},  mif.read_request_addr, 0);
    chk({pfx, "_wlen"},   mif.write_len, 0);
`ifdef MEM_COPY_CHECKSUM_EN
    chk({pfx, "_csum"},   checksum, 0);
`endif
  endtask

  initial begin
    int base;
    setup(0, 0, 0, 0, 0, 1);
    repeat (3) @(posedge clk);
    #3;
    chk_reset_outs("rst");
    rst_n = 1'b1;

    // basic copy of four words
    src_mem[0] = 32'd1; src_mem[1] = 32'd2; src_mem[2] = 32'd3; src_mem[3] = 32'hFFFF_FFFF;
    base = done_cnt;
    launch(32'h100, 32'h200, 32'd4, 0, 0, 0);
    chk("t1_rv", 32'(mif.read_request_valid), 1);
    chk("t1_wv", 32'(mif.write_request_valid), 1);
    chk("t1_busy", 32'(busy), 1);
    wait_done(base, 100);
    chk("t1_pops", pop_cnt, 4);
    chk("t1_rfires", rreq_fires, 1);
    chk("t1_wfires", wreq_fires, 1);
    chk("t1_sb_empty", sb.size(), 0);
`ifdef MEM_COPY_CHECKSUM_EN
    chk("t1_csum", checksum, exp_sum);
    chk("t1_csum_vec", checksum, 32'd5);
`endif

    // zero-length start: done only, no requests
    base = done_cnt;
    launch(32'h10, 32'h20, 32'd0, 0, 0, 1);
    chk("t2_done", 32'(done), 1);
    chk("t2_busy", 32'(busy), 1);
    @(posedge clk); #3;
    chk("t2_done_off", 32'(done), 0);
    chk("t2_busy_off", 32'(busy), 0);
    repeat (3) @(posedge clk);
    #3;
    chk("t2_rv_seen", rv_seen, 0);
    chk("t2_wv_seen", wv_seen, 0);
    chk("t2_done_cnt", done_cnt, base + 1);

    // write side stalled: FIFO fills, read side backs off
    base = done_cnt;
    launch(32'h1000, 32'h2000, 32'd20, 30, 0, 1);
    repeat (22) @(posedge clk);
    #3;
    chk("t3_pushes", push_cnt, 8);
    chk("t3_pops", pop_cnt, 0);
    chk("t3_rdrdy", 32'(mif.read_data_ready), 0);
    chk("t3_wdv", 32'(mif.write_data_valid), 1);
    wait_done(base, 300);
    chk("t3_pops_all", pop_cnt, 20);
    chk("t3_sb_empty", sb.size(), 0);
`ifdef MEM_COPY_CHECKSUM_EN
    chk("t3_csum", checksum, exp_sum);
`endif

    // unaligned addresses, write request accepted late
    base = done_cnt;
    launch(32'h103, 32'h207, 32'd3, 0, 5, 1);
    chk("t4_raddr", mif.read_request_addr, 32'h100);
    chk("t4_waddr", mif.write_request_addr, 32'h204);
    repeat (3) @(posedge clk);
    #3;
    chk("t4_rv_dropped", 32'(mif.read_request_valid), 0);
    chk("t4_wv_held", 32'(mif.write_request_valid), 1);
    wait_done(base, 100);
    chk("t4_pops", pop_cnt, 3);
    chk("t4_wfires", wreq_fires, 1);

    // reset in the middle of a transfer, then a clean one
    base = done_cnt;
    launch(32'h40, 32'h80, 32'd10, 0, 0, 1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #2;
      if (pop_cnt >= 3) break;
    end
    chk("t5_beat3", 32'(pop_cnt >= 3), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("t5");
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    chk("t5_no_done", done_cnt, base);
    launch(32'h300, 32'h400, 32'd2, 0, 0, 1);
    wait_done(base, 100);
    chk("t5_pops", pop_cnt, 2);
    chk("t5_sb_empty", sb.size(), 0);
`ifdef MEM_COPY_CHECKSUM_EN
    chk("t5_csum", checksum, exp_sum);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
